// File: rtl/writeback_stage.sv
// RV32 writeback stage: selects register-file write data by opcode and aligns,
// extends and writes back load data that arrives from a variable-latency memory.
module writeback_stage #(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned REG_AW   = 5,
  parameter int unsigned MAX_WAIT = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       instruction,
  input  logic [DATA_W-1:0] pc_plus_4,
  input  logic [DATA_W-1:0] alu_out,
  input  logic              mem_rvalid,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              wb_en,
  output logic [REG_AW-1:0] wb_addr,
  output logic [DATA_W-1:0] wb_data,
  output logic              illegal,
  output logic              load_timeout
);

  localparam int unsigned CNT_W = 8;

  localparam logic [6:0] OPC_ZERO   = 7'h00;
  localparam logic [6:0] OPC_LOAD   = 7'h03;
  localparam logic [6:0] OPC_OP_IMM = 7'h13;
  localparam logic [6:0] OPC_AUIPC  = 7'h17;
  localparam logic [6:0] OPC_STORE  = 7'h23;
  localparam logic [6:0] OPC_OP     = 7'h33;
  localparam logic [6:0] OPC_LUI    = 7'h37;
  localparam logic [6:0] OPC_BRANCH = 7'h63;
  localparam logic [6:0] OPC_JALR   = 7'h67;
  localparam logic [6:0] OPC_JAL    = 7'h6F;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    WAIT = 1'b1
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   wait_cnt_q, wait_cnt_d;
  logic [REG_AW-1:0]  ld_rd_q, ld_rd_d;
  logic [2:0]         ld_f3_q, ld_f3_d;
  logic [1:0]         ld_off_q, ld_off_d;
  logic               wb_en_q, wb_en_d;
  logic [REG_AW-1:0]  wb_addr_q, wb_addr_d;
  logic [DATA_W-1:0]  wb_data_q, wb_data_d;
  logic               illegal_q, illegal_d;
  logic               timeout_q, timeout_d;

  logic [6:0]         opcode_c;
  logic [REG_AW-1:0]  rd_c;
  logic [DATA_W-1:0]  shifted_c;
  logic [DATA_W-1:0]  load_data_c;
  logic               load_bad_c;
  logic               alu_write_c;
  logic [DATA_W-1:0]  alu_data_c;

  assign opcode_c = instruction[6:0];
  assign rd_c     = REG_AW'(instruction[11:7]);
  assign in_ready = (state_q == IDLE) & ~rst;

  // Load alignment and extension, with misaligned / unknown funct3 detection.
  always_comb begin
    shifted_c   = mem_rdata >> {ld_off_q, 3'b000};
    load_data_c = mem_rdata;
    load_bad_c  = 1'b0;
    unique case (ld_f3_q)
      F3_LB:  load_data_c = {{(DATA_W-8){shifted_c[7]}}, shifted_c[7:0]};
      F3_LBU: load_data_c = {{(DATA_W-8){1'b0}}, shifted_c[7:0]};
      F3_LH: begin
        load_data_c = {{(DATA_W-16){shifted_c[15]}}, shifted_c[15:0]};
        load_bad_c  = ld_off_q[0];
      end
      F3_LHU: begin
        load_data_c = {{(DATA_W-16){1'b0}}, shifted_c[15:0]};
        load_bad_c  = ld_off_q[0];
      end
      F3_LW: begin
        load_data_c = mem_rdata;
        load_bad_c  = (ld_off_q != 2'b00);
      end
      default: load_bad_c = 1'b1;
    endcase
  end

  // Non-load writeback data select.
  always_comb begin
    alu_write_c = 1'b0;
    alu_data_c  = alu_out;
    unique case (opcode_c)
      OPC_OP, OPC_OP_IMM, OPC_AUIPC: alu_write_c = 1'b1;
      OPC_LUI: begin
        alu_write_c = 1'b1;
        alu_data_c  = DATA_W'({instruction[31:12], 12'b0});
      end
      OPC_JAL, OPC_JALR: begin
        alu_write_c = 1'b1;
        alu_data_c  = pc_plus_4;
      end
      default: alu_write_c = 1'b0;
    endcase
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    ld_rd_d    = ld_rd_q;
    ld_f3_d    = ld_f3_q;
    ld_off_d   = ld_off_q;
    wb_en_d    = 1'b0;
    wb_addr_d  = wb_addr_q;
    wb_data_d  = wb_data_q;
    illegal_d  = 1'b0;
    timeout_d  = timeout_q;

    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          if (alu_write_c) begin
            wb_en_d   = (rd_c != '0);
            wb_addr_d = rd_c;
            wb_data_d = alu_data_c;
          end else if (opcode_c == OPC_LOAD) begin
            state_d    = WAIT;
            wait_cnt_d = '0;
            ld_rd_d    = rd_c;
            ld_f3_d    = instruction[14:12];
            ld_off_d   = alu_out[1:0];
          end else if (opcode_c != OPC_STORE && opcode_c != OPC_BRANCH &&
                       opcode_c != OPC_ZERO) begin
            illegal_d = 1'b1;
          end
        end
      end
      WAIT: begin
        if (mem_rvalid) begin
          state_d    = IDLE;
          wait_cnt_d = '0;
          if (load_bad_c) begin
            illegal_d = 1'b1;
          end else begin
            wb_en_d   = (ld_rd_q != '0);
            wb_addr_d = ld_rd_q;
            wb_data_d = load_data_c;
          end
        end else if (wait_cnt_q == CNT_W'(MAX_WAIT)) begin
          state_d    = IDLE;
          wait_cnt_d = '0;
          timeout_d  = 1'b1;
        end else begin
          wait_cnt_d = wait_cnt_q + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      wait_cnt_q <= '0;
      ld_rd_q    <= '0;
      ld_f3_q    <= '0;
      ld_off_q   <= '0;
      wb_en_q    <= 1'b0;
      wb_addr_q  <= '0;
      wb_data_q  <= '0;
      illegal_q  <= 1'b0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      ld_rd_q    <= ld_rd_d;
      ld_f3_q    <= ld_f3_d;
      ld_off_q   <= ld_off_d;
      wb_en_q    <= wb_en_d;
      wb_addr_q  <= wb_addr_d;
      wb_data_q  <= wb_data_d;
      illegal_q  <= illegal_d;
      timeout_q  <= timeout_d;
    end
  end

  assign wb_en        = wb_en_q;
  assign wb_addr      = wb_addr_q;
  assign wb_data      = wb_data_q;
  assign illegal      = illegal_q;
  assign load_timeout = timeout_q;

endmodule
